// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding word memory responder with fixed response latency
// Accepts one load/store in IDLE, waits LATENCY edges, then pulses a registered response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        accept;
  logic        fire;
  logic        addr_err;
  logic        commit;
  logic [AW-1:0] word_idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept   = req_valid && req_ready && (state == IDLE);
  // fire marks edge E_LATENCY: the array is read or written exactly here
  assign fire     = (state == WAIT) && (cnt == 4'd0);
  assign addr_err = (cap_addr[1:0] != 2'b00) || (cap_addr >= ADDR_LIMIT);
  assign word_idx = cap_addr[AW+1:2];
  assign commit   = fire && cap_write && !addr_err;
  assign busy     = (state == WAIT) || (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // req_ready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      if (fire) begin
        resp_err   <= addr_err;
        resp_rdata <= (cap_write || addr_err) ? 32'd0 : mem[word_idx];
      end
    end
  end

  // Storage is deliberately not reset; an async reset forces IDLE so no commit can follow it
  always_ff @(posedge clk) begin
    if (commit && rst) begin
      mem[word_idx] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
// Expected results come from a word-array model indexed by byte address / 4.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_known [DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (longint'(addr) >= longint'(4 * DEPTH));
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    return int'(addr / 4);
  endfunction

  // Drives one request from a negedge and collects what the DUT did; returns at the response negedge
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output logic [31:0] rdata, output logic err,
                        output int lat, output longint acc_time, output bit busy_ok,
                        output bit timeout);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    timeout   = 1'b0;
    busy_ok   = 1'b1;
    lat       = -1;
    acc_time  = 0;
    rdata     = 32'd0;
    err       = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      timeout   = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    if (hold) begin
      req_write = $urandom_range(0, 1);
      req_addr  = $urandom_range(0, DEPTH - 1) * 4;
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) timeout = 1'b1;
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, resp_err, busy, resp_rdata} !== 36'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got ready=%b valid=%b err=%b busy=%b rdata=%h exp all zero",
                 i, req_ready, resp_valid, resp_err, busy, resp_rdata);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b exp=0", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_release got ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t;
    bit          bok, to;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, t, bok, to);
    model_mem[4] = 32'hDEADBEEF;
    model_known[4] = 1'b1;
    checks++;
    if (to || lat != LAT || rd !== 32'd0 || er !== 1'b0 || !bok) begin
      failures++;
      $display("FAIL store_10 got to=%b lat=%0d rdata=%h err=%b busy_ok=%b exp lat=%0d rdata=0 err=0",
               to, lat, rd, er, bok, LAT);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL resp_one_cycle got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || lat != LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL load_10 got to=%b lat=%0d rdata=%h err=%b exp lat=%0d rdata=deadbeef err=0",
               to, lat, rd, er, LAT);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL resp_hold got rdata=%h err=%b valid=%b exp rdata=deadbeef err=0 valid=0",
               resp_rdata, resp_err, resp_valid);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t;
    bit          bok, to;
    do_req(1'b1, 32'h13, 32'h55AA55AA, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || lat != LAT || rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_store got to=%b lat=%0d rdata=%h err=%b exp rdata=0 err=1", to, lat, rd, er);
    end
    do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL after_misaligned got rdata=%h err=%b exp rdata=deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t;
    bit          bok, to;
    do_req(1'b0, 32'h400, 32'h0, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL load_400 got rdata=%h err=%b exp rdata=0 err=1", rd, er);
    end
    do_req(1'b1, 32'h3FC, 32'h12345678, 1'b0, rd, er, lat, t, bok, to);
    model_mem[255] = 32'h12345678;
    model_known[255] = 1'b1;
    do_req(1'b1, 32'hFFFF_FFFC, 32'hA5A5A5A5, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL store_fffffffc got rdata=%h err=%b exp rdata=0 err=1", rd, er);
    end
    do_req(1'b0, 32'h3FC, 32'h0, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || rd !== 32'h12345678 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_3fc got rdata=%h err=%b exp rdata=12345678 err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t, t_prev;
    bit          bok, to, wr;
    logic [31:0] addr, wd;
    int          idx;
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      wr   = (i < 4) ? 1'b1 : 1'b0;
      idx  = (i < 4) ? (16 + i) : (16 + i - 4);
      addr = 32'(idx * 4);
      wd   = $urandom;
      do_req(wr, addr, wd, 1'b1, rd, er, lat, t, bok, to);
      if (wr) begin
        model_mem[idx] = wd;
        model_known[idx] = 1'b1;
      end
      checks++;
      if (to || !bok || er !== 1'b0 || rd !== (wr ? 32'd0 : model_mem[idx])) begin
        failures++;
        $display("FAIL b2b_resp i=%0d got to=%b busy_ok=%b err=%b rdata=%h exp err=0 rdata=%h",
                 i, to, bok, er, rd, wr ? 32'd0 : model_mem[idx]);
      end
      if (i > 0) begin
        checks++;
        if ((t - t_prev) / 10 != LAT + 2) begin
          failures++;
          $display("FAIL b2b_spacing i=%0d got=%0d exp=%0d", i, (t - t_prev) / 10, LAT + 2);
        end
      end
      t_prev = t;
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t;
    bit          bok, to, seen;
    int          n;
    do_req(1'b1, 32'h20, 32'h0, 1'b0, rd, er, lat, t, bok, to);
    model_mem[8] = 32'h0;
    model_known[8] = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_outputs got ready=%b valid=%b busy=%b exp 000", req_ready, resp_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid_no_resp got resp_valid seen=1 exp=0");
    end
    do_req(1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, t, bok, to);
    checks++;
    if (to || rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL mid_load_20 got rdata=%h err=%b exp rdata=0 err=0", rd, er);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd;
    logic        er;
    int          lat;
    longint      t;
    bit          bok, to, wr, e;
    logic [31:0] addr, wd;
    int          r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       addr = $urandom_range(0, DEPTH - 1) * 4;
      else if (r < 8)  addr = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
      else if (r == 8) addr = 4 * DEPTH + $urandom_range(0, 1000) * 4;
      else             addr = 32'hFFFF_FFFC;
      wr = $urandom_range(0, 1);
      wd = $urandom;
      e  = model_err(addr);
      do_req(wr, addr, wd, 1'b0, rd, er, lat, t, bok, to);
      checks++;
      if (to || lat != LAT || !bok || er !== e) begin
        failures++;
        $display("FAIL rand_resp i=%0d addr=%h got to=%b lat=%0d busy_ok=%b err=%b exp lat=%0d err=%b",
                 i, addr, to, lat, bok, er, LAT, e);
      end
      if (wr || e) begin
        checks++;
        if (rd !== 32'd0) begin
          failures++;
          $display("FAIL rand_zero i=%0d addr=%h got rdata=%h exp=0", i, addr, rd);
        end
      end else if (model_known[model_idx(addr)]) begin
        checks++;
        if (rd !== model_mem[model_idx(addr)]) begin
          failures++;
          $display("FAIL rand_load i=%0d addr=%h got rdata=%h exp=%h", i, addr, rd, model_mem[model_idx(addr)]);
        end
      end
      if (wr && !e) begin
        model_mem[model_idx(addr)] = wd;
        model_known[model_idx(addr)] = 1'b1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'd0;
      model_known[i] = 1'b0;
    end
    test_reset;
    test_store_load;
    test_misaligned;
    test_out_of_range;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 The block SHALL have a parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two, 16..4096).
REQ-002 The block SHALL have a parameter LATENCY, default 2, giving the number of wait edges from request acceptance to response (legal range 1..15).

Interface
REQ-003 The block SHALL have one clock, clk, and a reset, rst, that is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  the CPU-side initiator presents a load or store request.
REQ-007 req_write  input  1  1 = store, 0 = load; sampled only on acceptance.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_ready  output  1  the responder can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-013 resp_err  output  1  the request was misaligned or out of range; valid with resp_valid.
REQ-014 busy  output  1  a request is outstanding (state WAIT or RESP).

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, and only from the first rising edge after rst is released.
REQ-017 Acceptance SHALL occur at a rising edge where req_valid=1 and req_ready=1. Call this edge E0.
REQ-018 At E0 the block SHALL capture req_write, req_addr and req_wdata, enter WAIT, and load the wait counter with LATENCY-1.
REQ-019 In WAIT, the block SHALL decrement the counter at each edge while it is nonzero, and SHALL enter RESP at the edge where the counter is 0.
REQ-020 RESP SHALL therefore be entered at edge E_LATENCY, counted from E0.
REQ-021 resp_valid SHALL be registered and equal to 1 only in RESP, which lasts exactly one cycle.
REQ-022 At edge E_(LATENCY+1) the FSM SHALL return to IDLE; the earliest next acceptance is at edge E_(LATENCY+2).
REQ-023 Only one request SHALL be outstanding; req_valid, req_addr and req_wdata SHALL be ignored outside IDLE.
REQ-024 The word index SHALL be captured_addr[log2(DEPTH_WORDS)+1:2].
REQ-025 resp_err SHALL be 1 if captured_addr[1:0] != 0 or if captured_addr >= 4*DEPTH_WORDS.
REQ-026 A store SHALL commit to the array at edge E_LATENCY, and only if resp_err=0; an erroring store SHALL leave the array unchanged.
REQ-027 A load SHALL sample the array at edge E_LATENCY into resp_rdata; resp_rdata SHALL be 0 when the request is an error.
REQ-028 resp_rdata and resp_err SHALL hold their values after RESP until the next response overwrites them.
REQ-029 A load issued after a store to the same word SHALL return the stored data.
REQ-030 Address 0xFFFF_FFFC SHALL be an out-of-range error and SHALL NOT wrap to any array word.

Reset
REQ-031 While rst=0, the outputs SHALL be: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, and the counter SHALL be 0.
REQ-032 Reset SHALL NOT clear the storage array; array contents are undefined until first written.
REQ-033 If rst is asserted in WAIT, the pending request SHALL be dropped with no array write and no resp_valid.
REQ-034 If rst is asserted at or before edge E_LATENCY, the store SHALL NOT commit.

Verification
REQ-035 Reset: rst=0 for 3 cycles, then 1 -> all outputs are 0 during reset, and req_ready=1 from the first edge after release.
REQ-036 Store then load, LATENCY=2:
- store addr 0x10, data 0xDEADBEEF -> resp_valid high one cycle at E2 with rdata=0 and err=0;
- then load addr 0x10 -> rdata=0xDEADBEEF at E2.
REQ-037 Misaligned store to addr 0x13 -> resp_err=1 and rdata=0; a following load of addr 0x10 still returns 0xDEADBEEF.
REQ-038 Out of range, DEPTH_WORDS=256:
- load addr 0x400 -> resp_err=1;
- load addr 0x3FC after storing 0x12345678 there -> returns 0x12345678 with err=0.
REQ-039 Back-to-back requests with req_valid held high -> acceptances spaced exactly LATENCY+2 cycles apart, busy high between acceptance and response, and no request lost or duplicated.
REQ-040 Reset mid-operation: accept a store of 0xCAFEF00D to addr 0x20 (prior content 0x0), then pulse rst=0 in WAIT -> no resp_valid, and a later load of 0x20 returns 0x0.
